// File: rtl/result_arbiter_pkg.sv
// Shared types for result_write_arbiter: buffered lane entry, control FSM states
// and the pixel colour expansion used on the display port.
package result_arbiter_pkg;

    localparam int ENTRY_COL_BITS = 8;
    localparam int ENTRY_ROW_BITS = 8;

    typedef struct packed {
        logic [ENTRY_COL_BITS-1:0] col;
        logic [ENTRY_ROW_BITS-1:0] row;
        logic                      data;
    } lane_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // A binarised pixel is shown as black or white on all three channels.
    function automatic logic [2:0] pixel_rgb(input logic bit_val);
        return {3{bit_val}};
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane pixel FIFO: power-of-two depth, synchronous push/pop, count-based
// full/empty so a full FIFO is distinguishable from an empty one.
module lane_fifo
    import result_arbiter_pkg::*;
#(
    parameter int DEPTH_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_push,
    input  logic                i_pop,
    input  lane_entry_t         i_entry,
    output lane_entry_t         o_entry,
    output logic                o_full,
    output logic                o_empty,
    output logic [DEPTH_BITS:0] o_count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    lane_entry_t           r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_entry  = r_mem[r_rd_ptr];
    assign w_do_pop = i_pop && !o_empty;
    // The pop frees a slot at the same edge, so a full lane still takes a push alongside it.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (DEPTH_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Buffers per-lane binarised pixel writes and serialises them round-robin onto one
// display write port. Optional RESULT_PIXEL_COUNT_EN adds the oPixelCount strobe counter.
module result_write_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int WIDTH_BITS      = ENTRY_COL_BITS,
    parameter int HEIGHT_BITS     = ENTRY_ROW_BITS,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             iStart,
    input  logic                             iFrameDone,
    input  logic [NUM_LANES*WIDTH_BITS-1:0]  iCol,
    input  logic [NUM_LANES*HEIGHT_BITS-1:0] iRow,
    input  logic [NUM_LANES-1:0]             iData,
    input  logic [NUM_LANES-1:0]             iWren,
    output logic [NUM_LANES-1:0]             oLaneFull,
    output logic [NUM_LANES-1:0]             oOverflow,
    output logic [HEIGHT_BITS-1:0]           oX,
    output logic [WIDTH_BITS-1:0]            oY,
    output logic [2:0]                       oR,
    output logic [2:0]                       oG,
    output logic [2:0]                       oB,
    output logic                             oWren,
    output logic                             oDrained
`ifdef RESULT_PIXEL_COUNT_EN
    ,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]  oPixelCount
`endif
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam logic [FIFO_DEPTH_BITS:0] FULL_COUNT = (FIFO_DEPTH_BITS + 1)'(1 << FIFO_DEPTH_BITS);

    arb_state_t                r_state;
    arb_state_t                w_state_next;
    logic                      w_accept_en;
    logic                      w_drained;

    logic [LANE_W-1:0]         r_rr_ptr;
    logic [LANE_W-1:0]         w_probe;
    logic [LANE_W-1:0]         w_grant_idx;
    logic                      w_grant_valid;

    logic [NUM_LANES-1:0]      w_push_req;
    logic [NUM_LANES-1:0]      w_pop;
    logic [NUM_LANES-1:0]      w_full;
    logic [NUM_LANES-1:0]      w_empty;
    logic [NUM_LANES-1:0]      w_drop;
    logic                      w_all_empty;
    lane_entry_t               w_lane_in  [NUM_LANES];
    lane_entry_t               w_lane_out [NUM_LANES];
    logic [FIFO_DEPTH_BITS:0]  w_count    [NUM_LANES];
    lane_entry_t               w_sel_entry;

    logic [NUM_LANES-1:0]      r_overflow;
    logic                      r_wren;
    logic [HEIGHT_BITS-1:0]    r_x;
    logic [WIDTH_BITS-1:0]     r_y;
    logic [2:0]                r_rgb;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign w_push_req[gi] = iWren[gi] && w_accept_en;
        assign w_pop[gi]      = w_grant_valid && (w_grant_idx == LANE_W'(gi));
        // Only a push that meets a full lane with no pop in the same edge is lost.
        assign w_drop[gi]     = w_push_req[gi] && w_full[gi] && !w_pop[gi];
        assign w_lane_in[gi]  = '{col:  ENTRY_COL_BITS'(iCol[gi*WIDTH_BITS +: WIDTH_BITS]),
                                  row:  ENTRY_ROW_BITS'(iRow[gi*HEIGHT_BITS +: HEIGHT_BITS]),
                                  data: iData[gi]};
        assign oLaneFull[gi]  = (w_count[gi] == FULL_COUNT);

        lane_fifo #(
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .i_push  (w_push_req[gi]),
            .i_pop   (w_pop[gi]),
            .i_entry (w_lane_in[gi]),
            .o_entry (w_lane_out[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_count (w_count[gi])
        );
    end

    assign w_all_empty = &w_empty;
    assign w_sel_entry = w_lane_out[w_grant_idx];

    // Round-robin search: first non-empty lane at or above rr_ptr, wrapping.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_probe       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_probe = r_rr_ptr + LANE_W'(i);
            if (w_accept_en && !w_grant_valid && !w_empty[w_probe]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_probe;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept_en  = 1'b1;
        w_drained    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iFrameDone) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the final strobe to leave the output register too.
                if (w_all_empty && !r_wren) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_accept_en = 1'b0;
                w_drained   = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wren     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_rgb      <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= '0;
        end else begin
            r_wren     <= w_grant_valid;
            r_overflow <= r_overflow | w_drop;
            if (w_grant_valid) begin
                r_x      <= HEIGHT_BITS'(w_sel_entry.row);
                r_y      <= WIDTH_BITS'(w_sel_entry.col);
                r_rgb    <= pixel_rgb(w_sel_entry.data);
                r_rr_ptr <= w_grant_idx + LANE_W'(1);
            end
        end
    end

`ifdef RESULT_PIXEL_COUNT_EN
    localparam int PC_W = WIDTH_BITS + HEIGHT_BITS + 1;
    logic [PC_W-1:0] r_pixel_count;

    // Advances on the edge that raises oWren, so the count already includes the visible strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pixel_count <= '0;
        end else if (w_grant_valid && (r_pixel_count != {PC_W{1'b1}})) begin
            r_pixel_count <= r_pixel_count + PC_W'(1);
        end
    end

    assign oPixelCount = r_pixel_count;
`endif

    assign oOverflow = r_overflow;
    assign oWren     = r_wren;
    assign oX        = r_x;
    assign oY        = r_y;
    assign oR        = r_rgb;
    assign oG        = r_rgb;
    assign oB        = r_rgb;
    assign oDrained  = w_drained;

endmodule

// File: tb/tb_result_write_arbiter.sv
// Scoreboard bench for result_write_arbiter: expected pixels are queued in the
// order the round-robin arbiter must emit them and popped on every oWren strobe.
module tb_result_write_arbiter;

    localparam int NL = 4;
    localparam int WB = 8;
    localparam int HB = 8;

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              iStart     = 1'b0;
    logic              iFrameDone = 1'b0;
    logic [NL*WB-1:0]  iCol       = '0;
    logic [NL*HB-1:0]  iRow       = '0;
    logic [NL-1:0]     iData      = '0;
    logic [NL-1:0]     iWren      = '0;
    logic [NL-1:0]     oLaneFull;
    logic [NL-1:0]     oOverflow;
    logic [HB-1:0]     oX;
    logic [WB-1:0]     oY;
    logic [2:0]        oR;
    logic [2:0]        oG;
    logic [2:0]        oB;
    logic              oWren;
    logic              oDrained;
`ifdef RESULT_PIXEL_COUNT_EN
    logic [WB+HB:0]    oPixelCount;
`endif

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [24:0] exp_q [$];
    logic [24:0] mon_exp;

    always #5 clock = ~clock;

    result_write_arbiter #(
        .NUM_LANES       (NL),
        .WIDTH_BITS      (WB),
        .HEIGHT_BITS     (HB),
        .FIFO_DEPTH_BITS (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iStart      (iStart),
        .iFrameDone  (iFrameDone),
        .iCol        (iCol),
        .iRow        (iRow),
        .iData       (iData),
        .iWren       (iWren),
        .oLaneFull   (oLaneFull),
        .oOverflow   (oOverflow),
        .oX          (oX),
        .oY          (oY),
        .oR          (oR),
        .oG          (oG),
        .oB          (oB),
        .oWren       (oWren),
        .oDrained    (oDrained)
`ifdef RESULT_PIXEL_COUNT_EN
        ,
        .oPixelCount (oPixelCount)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display port packing: {oX=row, oY=col, R, G, B}.
    function automatic logic [24:0] pix(input logic [7:0] col, input logic [7:0] row, input logic d);
        return {row, col, {9{d}}};
    endfunction

    task automatic set_lane(input int l, input logic [7:0] col, input logic [7:0] row,
                            input logic d, input bit add_exp);
        iCol[l*WB +: WB] = col;
        iRow[l*HB +: HB] = row;
        iData[l]         = d;
        iWren[l]         = 1'b1;
        if (add_exp) exp_q.push_back(pix(col, row, d));
    endtask

    task automatic do_reset_start();
        reset      = 1'b1;
        iWren      = '0;
        iStart     = 1'b0;
        iFrameDone = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        iStart = 1'b1;
        @(negedge clock);
        iStart = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clock);
        check_value(tag, 32'(exp_q.size()), 32'd0);
        @(negedge clock);
    endtask

    // Strobe monitor: one line per display write, compared against the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if (oWren === 1'b1) begin
                $display("strobe x=%0d y=%0d rgb=%b%b%b", oX, oY, oR, oG, oB);
                if (exp_q.size() == 0) begin
                    check_value("spurious_strobe", 32'(oWren), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_value("pixel", 32'({oX, oY, oR, oG, oB}), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle behaviour
        repeat (2) @(negedge clock);
        check_value("rst_wren", 32'(oWren), 32'd0);
        check_value("rst_xy", 32'({oX, oY}), 32'd0);
        check_value("rst_rgb", 32'({oR, oG, oB}), 32'd0);
        check_value("rst_full", 32'(oLaneFull), 32'd0);
        check_value("rst_ovf", 32'(oOverflow), 32'd0);
        check_value("rst_drained", 32'(oDrained), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_value("idle_wren", 32'(oWren), 32'd0);
        iStart = 1'b1;
        @(negedge clock);
        iStart = 1'b0;
        check_value("run_wren", 32'(oWren), 32'd0);
        check_value("run_drained", 32'(oDrained), 32'd0);

        // Single write on lane 2 with one-cycle latency
        set_lane(2, 8'd5, 8'd9, 1'b1, 1'b1);
        @(negedge clock);
        iWren = '0;
        check_value("lat_early", 32'(oWren), 32'd0);
        @(negedge clock);
        check_value("lat_strobe", 32'(oWren), 32'd1);
        wait_drain("drain_single");

        // All lanes in one cycle from rr_ptr=0: lane order 0,1,2,3
        do_reset_start();
        for (int l = 0; l < NL; l++) set_lane(l, 8'(16 + l), 8'(32 + l), (l % 2) == 1, 1'b1);
        @(negedge clock);
        iWren = '0;
        wait_drain("drain_all4");

        // Lane 1 back-to-back: drained as fast as it fills
        do_reset_start();
        for (int k = 0; k < 6; k++) begin
            set_lane(1, 8'(40 + k), 8'(60 + k), (k % 2) == 1, 1'b1);
            @(negedge clock);
            check_value("b2b_full", 32'(oLaneFull), 32'd0);
            check_value("b2b_ovf", 32'(oOverflow), 32'd0);
        end
        iWren = '0;
        wait_drain("drain_b2b");

        // Sustained 4-lane writes: lane 3 fills after edge 4, all full after edge 5;
        // the 6th write drops on lanes 1..3 while lane 0 pops alongside its push.
        do_reset_start();
        for (int r = 1; r <= 5; r++)
            for (int l = 0; l < NL; l++)
                exp_q.push_back(pix(8'(l*16 + r), 8'(128 + l*16 + r), ((l + r) % 2) == 1));
        exp_q.push_back(pix(8'(6), 8'(134), 1'b0));
        for (int r = 1; r <= 6; r++) begin
            for (int l = 0; l < NL; l++) set_lane(l, 8'(l*16 + r), 8'(128 + l*16 + r), ((l + r) % 2) == 1, 1'b0);
            @(negedge clock);
            if (r == 4) check_value("sat_full_e4", 32'(oLaneFull), 32'h8);
            if (r == 5) check_value("sat_full_e5", 32'(oLaneFull), 32'hF);
            if (r == 5) check_value("sat_ovf_e5", 32'(oOverflow), 32'h0);
            if (r == 6) check_value("sat_ovf_e6", 32'(oOverflow), 32'hE);
        end
        iWren = '0;
        wait_drain("drain_sat");
        check_value("ovf_sticky", 32'(oOverflow), 32'hE);
`ifdef RESULT_PIXEL_COUNT_EN
        check_value("pixel_count", 32'(oPixelCount), 32'd21);
`endif

        // Frame done with 3 pending: DRAIN, 3 strobes, DONE after the output empties
        do_reset_start();
        for (int l = 0; l < 3; l++) set_lane(l, 8'(70 + l), 8'(90 + l), 1'b1, 1'b1);
        iFrameDone = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clock);
            if (n == 1) iWren = '0;
            check_value("drained_t", 32'(oDrained), 32'(n >= 6));
        end
        check_value("drain_left", 32'(exp_q.size()), 32'd0);
        for (int l = 0; l < NL; l++) set_lane(l, 8'(200), 8'(201), 1'b1, 1'b0);
        repeat (6) @(negedge clock);
        iWren = '0;
        repeat (3) @(negedge clock);
        check_value("done_ovf", 32'(oOverflow), 32'd0);
        check_value("done_full", 32'(oLaneFull), 32'd0);
        check_value("done_hold", 32'(oDrained), 32'd1);

        // Reset in the middle of DRAIN discards everything
        do_reset_start();
        for (int l = 0; l < NL; l++) set_lane(l, 8'(110 + l), 8'(120 + l), 1'b0, 1'b1);
        iFrameDone = 1'b1;
        @(negedge clock);
        iWren = '0;
        @(negedge clock);
        check_value("mid_strobe", 32'(oWren), 32'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_value("mid_rst_wren", 32'(oWren), 32'd0);
        check_value("mid_rst_drained", 32'(oDrained), 32'd0);
        check_value("mid_rst_xy", 32'({oX, oY}), 32'd0);
        repeat (2) @(negedge clock);
        reset      = 1'b0;
        iFrameDone = 1'b0;
        repeat (6) @(negedge clock);
        check_value("post_rst_wren", 32'(oWren), 32'd0);
        check_value("post_rst_full", 32'(oLaneFull), 32'd0);
        check_value("post_rst_drained", 32'(oDrained), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
